// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// At most one request is outstanding; responses are never back-pressured.
interface fetch_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem read at a time, buffers the
// returned word for decode, and handles trap/branch redirects with flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trap_valid,
  input  logic [31:0]                trap_target,
  input  logic                       branch_valid,
  input  logic [31:0]                branch_target,
  fetch_sequencer_if.master          imem,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_pc,
  output logic [31:0]                inst_data,
  output logic [31:0]                pc
);
  localparam int unsigned XLEN       = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] req_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            buf_free;
  logic            accept;

  // Trap wins over branch; targets are forced word-aligned.
  assign redirect    = trap_valid | branch_valid;
  assign redirect_pc = (trap_valid ? trap_target : branch_target) & ALIGN_MASK;

  assign buf_free       = !inst_valid || inst_ready;
  assign imem.imem_req  = rst_n && (state == REQ) && buf_free && !redirect;
  assign imem.imem_addr = pc;
  assign accept         = imem.imem_req && imem.imem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      req_pc     <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_data  <= '0;
    end else begin
      if (inst_ready) inst_valid <= 1'b0;

      case (state)
        BOOT: begin
          if (redirect) pc <= redirect_pc;
          state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (accept) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= imem.imem_rvalid ? REQ : DROP;
          end else if (imem.imem_rvalid) begin
            inst_valid <= 1'b1;
            inst_pc    <= req_pc;
            inst_data  <= imem.imem_rdata;
            state      <= REQ;
          end
        end
        DROP: begin
          // The stale response still owed by memory is swallowed here.
          if (redirect) pc <= redirect_pc;
          if (imem.imem_rvalid) state <= REQ;
        end
        default: state <= BOOT;
      endcase

      // Flush beats both consumption and capture.
      if (redirect) inst_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: a default-vector instance for most tests
// and a wrap-vector instance for the pc+4 rollover.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        trap_valid, branch_valid, inst_ready;
  logic [31:0] trap_target, branch_target;
  logic        inst_valid;
  logic [31:0] inst_pc, inst_data, pc;

  logic        mem_ready, auto_mem, man_rvalid, am_rvalid;
  logic [31:0] man_rdata, am_rdata;

  logic        inst_valid_w, rvalid_w;
  logic [31:0] inst_pc_w, inst_data_w, pc_w, rdata_w;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  fetch_sequencer_if imem_a ();
  fetch_sequencer_if imem_w ();

  assign imem_a.imem_ready  = mem_ready;
  assign imem_a.imem_rvalid = auto_mem ? am_rvalid : man_rvalid;
  assign imem_a.imem_rdata  = auto_mem ? am_rdata : man_rdata;
  assign imem_w.imem_ready  = 1'b1;
  assign imem_w.imem_rvalid = rvalid_w;
  assign imem_w.imem_rdata  = rdata_w;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem(imem_a),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data), .pc(pc)
  );

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(1'b0), .trap_target(32'h0),
    .branch_valid(1'b0), .branch_target(32'h0),
    .imem(imem_w),
    .inst_valid(inst_valid_w), .inst_ready(1'b1),
    .inst_pc(inst_pc_w), .inst_data(inst_data_w), .pc(pc_w)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1234;
  endfunction

  // One-cycle memory: answers every accepted request on the following cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      am_rvalid <= 1'b0;
      am_rdata  <= 32'h0;
    end else begin
      am_rvalid <= auto_mem && imem_a.imem_req && imem_a.imem_ready;
      am_rdata  <= data_of(imem_a.imem_addr);
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    trap_valid = 1'b0; trap_target = 32'h0;
    branch_valid = 1'b0; branch_target = 32'h0;
    inst_ready = 1'b1; mem_ready = 1'b1;
    auto_mem = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
    rvalid_w = 1'b0; rdata_w = 32'h0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    branch_valid = 1'b1; branch_target = 32'h0000_0ABC;
    trap_valid = 1'b0; trap_target = 32'h0;
    inst_ready = 1'b1; mem_ready = 1'b1;
    auto_mem = 1'b1; man_rvalid = 1'b0; man_rdata = 32'h0;
    rvalid_w = 1'b0; rdata_w = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (pc_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc_w got=%h exp=%h", pc_w, 32'hFFFF_FFFC); end
    total++; if ({inst_valid, inst_pc, inst_data} !== 65'h0) begin bad++;
      $display("FAIL reset_inst got=%b/%h/%h exp=0/0/0", inst_valid, inst_pc, inst_data); end
    total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req_during got=%b exp=0", imem_a.imem_req); end
    branch_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req_after got=%b exp=0", imem_a.imem_req); end
    @(negedge clk); #1;
    total++; if (imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h0) begin bad++;
      $display("FAIL reset_first_req got=%b/%h exp=1/00000000", imem_a.imem_req, imem_a.imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    int          n_del;
    int          last_del;
    exp_t        e;
    apply_reset();
    auto_mem = 1'b1;
    exp_addr = 32'h0; n_del = 0; last_del = -1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_a.imem_req && imem_a.imem_ready) begin
        total++; if (imem_a.imem_addr !== exp_addr) begin bad++;
          $display("FAIL stream_addr got=%h exp=%h", imem_a.imem_addr, exp_addr); end
        sb.push_back('{pc: exp_addr, data: data_of(exp_addr), cyc: c});
        exp_addr = exp_addr + 32'd4;
      end
      if (inst_valid && inst_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stream_extra got=%h exp=none", inst_pc); end
        else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst_data !== e.data) begin bad++;
            $display("FAIL stream_inst got=%h/%h exp=%h/%h", inst_pc, inst_data, e.pc, e.data); end
          total++; if (c - e.cyc != 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", c - e.cyc); end
        end
        if (last_del >= 0) begin
          total++; if (c - last_del != 2) begin bad++; $display("FAIL stream_rate got=%0d exp=2", c - last_del); end
        end
        last_del = c;
        n_del++;
      end
      @(negedge clk);
    end
    total++; if (n_del != 9) begin bad++; $display("FAIL stream_count got=%0d exp=9", n_del); end
  endtask

  task automatic test_backpressure();
    bit got;
    apply_reset();
    auto_mem = 1'b1; inst_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      if (inst_valid) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL bp_wait got=timeout exp=inst_valid"); end
    else begin
      for (int k = 0; k < 3; k++) begin
        total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b exp=0", imem_a.imem_req); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== data_of(32'h0)) begin bad++;
          $display("FAIL bp_hold got=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_pc, inst_data, data_of(32'h0)); end
        @(negedge clk); #1;
      end
      inst_ready = 1'b1;
      #1;
      total++; if (imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h4) begin bad++;
        $display("FAIL bp_release got=%b/%h exp=1/00000004", imem_a.imem_req, imem_a.imem_addr); end
    end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    @(negedge clk); #1;
    total++; if (imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h0) begin bad++;
      $display("FAIL br_first got=%b/%h exp=1/00000000", imem_a.imem_req, imem_a.imem_addr); end
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h0000_0103;
    #1;
    total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL br_wait_req got=%b exp=0", imem_a.imem_req); end
    @(negedge clk);
    branch_valid = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (imem_a.imem_req !== 1'b0 || pc !== 32'h100) begin bad++;
      $display("FAIL br_drop got=%b/%h exp=0/00000100", imem_a.imem_req, pc); end
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h100) begin bad++;
      $display("FAIL br_redirect got=%b/%b/%h exp=0/1/00000100", inst_valid, imem_a.imem_req, imem_a.imem_addr); end
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h0000_0040;
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    branch_valid = 1'b0; man_rvalid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h40) begin bad++;
      $display("FAIL br_same_cycle got=%b/%b/%h exp=0/1/00000040", inst_valid, imem_a.imem_req, imem_a.imem_addr); end
  endtask

  task automatic test_trap_priority();
    apply_reset();
    inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'h1111_2222;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b1 || inst_data !== 32'h1111_2222 || imem_a.imem_req !== 1'b0) begin bad++;
      $display("FAIL trap_setup got=%b/%h/%b exp=1/11112222/0", inst_valid, inst_data, imem_a.imem_req); end
    inst_ready = 1'b1;
    trap_valid = 1'b1; trap_target = 32'h200;
    branch_valid = 1'b1; branch_target = 32'h300;
    #1;
    total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL trap_req got=%b exp=0", imem_a.imem_req); end
    @(negedge clk);
    trap_valid = 1'b0; branch_valid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h200) begin bad++;
      $display("FAIL trap_target got=%b/%b/%h exp=0/1/00000200", inst_valid, imem_a.imem_req, imem_a.imem_addr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk); #1;
    total++; if (imem_w.imem_req !== 1'b1 || imem_w.imem_addr !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", imem_w.imem_req, imem_w.imem_addr); end
    @(negedge clk);
    rvalid_w = 1'b1; rdata_w = 32'hCAFE_F00D;
    #1;
    total++; if (pc_w !== 32'h0 || imem_w.imem_req !== 1'b0) begin bad++;
      $display("FAIL wrap_pc got=%h/%b exp=00000000/0", pc_w, imem_w.imem_req); end
    @(negedge clk);
    rvalid_w = 1'b0;
    #1;
    total++; if (inst_valid_w !== 1'b1 || inst_pc_w !== 32'hFFFF_FFFC || inst_data_w !== 32'hCAFE_F00D) begin bad++;
      $display("FAIL wrap_inst got=%b/%h/%h exp=1/fffffffc/cafef00d", inst_valid_w, inst_pc_w, inst_data_w); end
    total++; if (imem_w.imem_req !== 1'b1 || imem_w.imem_addr !== 32'h0) begin bad++;
      $display("FAIL wrap_second got=%b/%h exp=1/00000000", imem_w.imem_req, imem_w.imem_addr); end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'h7777_0000;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b1 || imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h4) begin bad++;
      $display("FAIL rst_setup got=%b/%b/%h exp=1/1/00000004", inst_valid, imem_a.imem_req, imem_a.imem_addr); end
    @(negedge clk);
    rst_n = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h8888_0000;
    #1;
    total++; if (imem_a.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_during got=%b exp=0", imem_a.imem_req); end
    @(negedge clk);
    rst_n = 1'b1; man_rvalid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || pc !== 32'h0 || imem_a.imem_req !== 1'b0) begin bad++;
      $display("FAIL rst_after got=%b/%h/%b exp=0/00000000/0", inst_valid, pc, imem_a.imem_req); end
    @(negedge clk); #1;
    total++; if (imem_a.imem_req !== 1'b1 || imem_a.imem_addr !== 32'h0) begin bad++;
      $display("FAIL rst_restart got=%b/%h exp=1/00000000", imem_a.imem_req, imem_a.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_trap_priority();
    test_wrap();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 Port trap_valid  input  1  SHALL request a redirect to trap_target.
REQ-005 Port trap_target  input  32  SHALL be the trap redirect address.
REQ-006 Port branch_valid  input  1  SHALL request a redirect to branch_target (taken branch or jump).
REQ-007 Port branch_target  input  32  SHALL be the branch/jump redirect address.
REQ-008 Port imem_req  output  1  SHALL indicate a valid instruction-memory read request.
REQ-009 Port imem_addr  output  32  SHALL be the request address.
REQ-010 Port imem_ready  input  1  SHALL accept the request in any cycle where imem_req=1 and imem_ready=1.
REQ-011 Port imem_rvalid  input  1  SHALL mark imem_rdata valid; it is never back-pressured.
REQ-012 Port imem_rdata  input  32  SHALL be the returned instruction word.
REQ-013 Port inst_valid  output  1  SHALL indicate inst_pc/inst_data hold an instruction for decode.
REQ-014 Port inst_ready  input  1  SHALL mark decode consuming the instruction when inst_valid=1.
REQ-015 Port inst_pc  output  32  SHALL be the address of the delivered instruction.
REQ-016 Port inst_data  output  32  SHALL be the delivered instruction word.
REQ-017 Port pc  output  32  SHALL expose the next fetch address register.

Function
REQ-018 States SHALL be BOOT, REQ, WAIT, DROP; at most one memory request SHALL be outstanding.
REQ-019 Redirect priority SHALL be trap over branch; a redirect cycle is any cycle with trap_valid or branch_valid high; the selected target SHALL have bits [1:0] forced to 2'b00.
REQ-020 BOOT: imem_req=0; next state REQ unconditionally; redirects in BOOT SHALL load pc and still go to REQ.
REQ-021 Output buffer free = !inst_valid || inst_ready.
REQ-022 REQ: imem_req SHALL be 1 exactly when buffer free and no redirect this cycle; imem_addr SHALL equal pc.
REQ-023 REQ, accept (imem_req & imem_ready): req_pc<=pc, pc<=pc+4, next state WAIT.
REQ-024 REQ, redirect: pc<=target, no request issued, stay REQ.
REQ-025 WAIT, imem_rvalid and no redirect: inst_valid<=1, inst_pc<=req_pc, inst_data<=imem_rdata, next state REQ.
REQ-026 WAIT, redirect with imem_rvalid same cycle: data discarded, pc<=target, next state REQ.
REQ-027 WAIT, redirect without imem_rvalid: pc<=target, next state DROP.
REQ-028 DROP: imem_req=0; next imem_rvalid SHALL be discarded and state SHALL go to REQ; a further redirect in DROP SHALL update pc (newest wins) without leaving DROP unless imem_rvalid is also high.
REQ-029 Any redirect SHALL clear inst_valid at the next edge (flush), overriding inst_ready and any capture.
REQ-030 inst_valid SHALL clear when inst_ready=1 and no new capture occurs that cycle; inst_pc/inst_data SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-031 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 imem_addr SHALL equal pc in all states; imem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-033 Minimum latency: request accepted in cycle N with imem_rvalid in N+1 SHALL give inst_valid=1 in N+2; sustained throughput with 1-cycle memory SHALL be one instruction per 2 cycles.

Reset
REQ-034 While rst_n=0 at an edge: state<=BOOT, pc<=RESET_VECTOR, inst_valid<=0, inst_pc<=0, inst_data<=0, req_pc<=0; imem_req=0 during and the cycle after.
REQ-035 Reset SHALL override every other input, including mid-WAIT/DROP; pending responses are the memory's responsibility (same reset).

Verification
REQ-036 Reset release, imem_ready=1, 1-cycle rvalid, inst_ready=1 -> imem_addr sequence 0x0,0x4,0x8; inst_pc 0x0,0x4 with matching data.
REQ-037 inst_ready=0 with inst_valid=1 -> imem_req=0, outputs held unchanged; inst_ready=1 -> next request issued same cycle.
REQ-038 branch_valid=1 target 0x103 in WAIT, rvalid next cycle -> response dropped, inst_valid=0, next imem_addr=0x100.
REQ-039 trap_valid (0x200) and branch_valid (0x300) same cycle in REQ -> no request that cycle, next imem_addr=0x200.
REQ-040 RESET_VECTOR=32'hFFFF_FFFC, run two fetches -> imem_addr 0xFFFF_FFFC then 0x0000_0000.
REQ-041 rst_n=0 pulsed during WAIT with inst_valid=1 -> next cycle inst_valid=0, pc=RESET_VECTOR, imem_req=0 for two cycles.
